// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: stereo frame FIFO feeding i2s_master via write_frame/full, with level/overflow/underrun debug.
module audio_frame_fifo #(
  parameter int DATA_W       = 24,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     in_l,
  input  logic [DATA_W-1:0]     in_r,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     frame_out_l,
  output logic [DATA_W-1:0]     frame_out_r,
  output logic                  write_frame,
  input  logic                  i2s_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [15:0]           underrun_cnt
);
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] AF_LVL   = AFULL_THRESH[DEPTH_LOG2:0];
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_nxt;
  logic [2*DATA_W-1:0] mem [1<<DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic primed, und_q, push, pop, und;
  assign in_ready    = reset_n && !clear && (level != FULL_LVL);
  assign almost_full = level >= AF_LVL;
  always_comb begin
    push      = in_valid && in_ready;
    pop       = state == IDLE && level != '0 && !i2s_full;
    und       = state == IDLE && primed && level == '0 && !i2s_full;
    state_nxt = state == IDLE ? (pop ? ISSUE : IDLE) : state == ISSUE ? HOLD : IDLE;
  end
  always_ff @(posedge clk)
    if (!reset_n || clear) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_l, in_r};
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      write_frame  <= 1'b0;
      frame_out_l  <= '0;
      frame_out_r  <= '0;
      overflow     <= 1'b0;
      underrun_cnt <= '0;
      primed       <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        {frame_out_l, frame_out_r} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        primed <= 1'b1;
      end
      write_frame <= pop;
      level       <= level + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      if (in_valid && !in_ready) overflow <= 1'b1;
      // count only the entry into the starved condition, not every starved cycle
      und_q <= und;
      if (und && !und_q && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_frame_fifo.sv
// tb_audio_frame_fifo: directed stimulus with a frame scoreboard checked on every write_frame pulse.
module tb_audio_frame_fifo;
  logic clk = 0, reset_n, clear, in_valid, in_ready, write_frame, i2s_full, almost_full, overflow;
  logic [23:0] in_l, in_r, frame_out_l, frame_out_r;
  logic [4:0] level;
  logic [15:0] underrun_cnt;
  logic [47:0] q[$];
  logic [47:0] exp_f;
  int total = 0, bad = 0, cyc = 0, last = -1;

  audio_frame_fifo dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_l(in_l), .in_r(in_r),
    .in_valid(in_valid), .in_ready(in_ready), .frame_out_l(frame_out_l),
    .frame_out_r(frame_out_r), .write_frame(write_frame), .i2s_full(i2s_full),
    .level(level), .almost_full(almost_full), .overflow(overflow), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk)
    if (write_frame === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected act=%0h exp=none", {frame_out_l, frame_out_r});
      end else begin
        exp_f = q.pop_front();
        if ({frame_out_l, frame_out_r} !== exp_f) begin
          bad++;
          $display("FAIL frame_data act=%0h exp=%0h", {frame_out_l, frame_out_r}, exp_f);
        end
      end
      if (last >= 0) begin
        total++;
        if (cyc - last < 3) begin
          bad++;
          $display("FAIL pulse_gap act=%0d exp>=3", cyc - last);
        end
      end
      last = cyc;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r, input bit acc);
    in_l = l;
    in_r = r;
    in_valid = 1;
    if (acc) q.push_back({l, r});
    tick;
    in_valid = 0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((q.size() != 0 || level != 0) && k < max) begin
      tick;
      k++;
    end
    chk("drain_timeout", 64'(k < max), 64'd1);
  endtask

  initial begin
    reset_n = 0; clear = 0; in_valid = 0; i2s_full = 0; in_l = 0; in_r = 0;
    tick;
    chk("rst_in_ready", 64'(in_ready), 0);
    tick;
    chk("rst_level", 64'(level), 0);
    chk("rst_wf", 64'(write_frame), 0);
    chk("rst_out", {16'h0, frame_out_l, frame_out_r}, 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_und", 64'(underrun_cnt), 0);
    reset_n = 1;
    #1;
    chk("rst_rel_in_ready", 64'(in_ready), 1);
    // latency
    push(24'h123456, 24'h654321, 1);
    chk("t1_level1", 64'(level), 1);
    chk("t1_wf0", 64'(write_frame), 0);
    tick;
    chk("t1_wf1", 64'(write_frame), 1);
    chk("t1_level0", 64'(level), 0);
    chk("t1_out", {16'h0, frame_out_l, frame_out_r}, 48'h123456654321);
    tick;
    chk("t1_wf_low", 64'(write_frame), 0);
    // fill
    i2s_full = 1;
    repeat (3) tick;
    for (int k = 0; k < 16; k++) begin
      push(24'(k), 24'(k + 24'h100), 1);
      chk("t2_level", 64'(level), 64'(k + 1));
      chk("t2_afull", 64'(almost_full), 64'(k + 1 >= 12));
    end
    chk("t2_in_ready", 64'(in_ready), 0);
    push(24'hBAD, 24'hBAD, 0);
    chk("t2_ovf", 64'(overflow), 1);
    chk("t2_level_full", 64'(level), 16);
    // order and wrap
    i2s_full = 0;
    drain(100);
    for (int k = 0; k < 20; k++) push(24'(k + 24'h200), 24'(k + 24'h300), 1);
    drain(100);
    // concurrent push and pop
    for (int k = 0; k < 15; k++) push(24'(k + 24'h400), 24'(k + 24'h500), 1);
    chk("t4_level", 64'(level), 10);
    drain(100);
    // clear during ISSUE
    chk("t6_ovf_pre", 64'(overflow), 1);
    i2s_full = 1;
    for (int k = 0; k < 6; k++) push(24'(k + 24'hA00), 24'(k + 24'hB00), 1);
    chk("t6_level6", 64'(level), 6);
    i2s_full = 0;
    tick;
    chk("t6_level5", 64'(level), 5);
    chk("t6_issue_wf", 64'(write_frame), 1);
    clear = 1;
    in_valid = 1;
    in_l = 24'hDEAD;
    in_r = 24'hBEEF;
    tick;
    clear = 0;
    in_valid = 0;
    q.delete();
    chk("t6_clr_level", 64'(level), 0);
    chk("t6_clr_wf", 64'(write_frame), 0);
    chk("t6_clr_ovf", 64'(overflow), 0);
    chk("t6_clr_und", 64'(underrun_cnt), 0);
    repeat (3) tick;
    chk("t6_clr_level_hold", 64'(level), 0);
    // underrun
    push(24'hC01, 24'hC02, 1);
    repeat (12) tick;
    chk("t5_level", 64'(level), 0);
    chk("t5_und1", 64'(underrun_cnt), 1);
    repeat (3) begin
      i2s_full = 1;
      repeat (2) tick;
      i2s_full = 0;
      repeat (2) tick;
    end
    chk("t5_und4", 64'(underrun_cnt), 4);
    // reset during ISSUE
    i2s_full = 1;
    for (int k = 0; k < 3; k++) push(24'(k + 24'hE00), 24'(k + 24'hF00), 1);
    i2s_full = 0;
    tick;
    chk("t6r_issue_wf", 64'(write_frame), 1);
    reset_n = 0;
    #1;
    chk("t6r_in_ready_a", 64'(in_ready), 0);
    tick;
    q.delete();
    chk("t6r_in_ready_b", 64'(in_ready), 0);
    chk("t6r_level", 64'(level), 0);
    chk("t6r_wf", 64'(write_frame), 0);
    chk("t6r_und", 64'(underrun_cnt), 0);
    chk("t6r_out", {16'h0, frame_out_l, frame_out_r}, 0);
    reset_n = 1;
    #1;
    chk("t6r_in_ready_rel", 64'(in_ready), 1);
    repeat (5) tick;
    chk("t6r_level_idle", 64'(level), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
